// File: rtl/m_key_debounce.sv
// m_key_debounce: synchronizes and debounces a raw key input and turns each
// accepted press into a single-cycle step, with optional auto-repeat while held.
module m_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic ck,
    input  logic res,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step
);

    localparam int unsigned MAXV = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] DC_TERM   = CW'(DEBOUNCE_CYCLES);
    // Repeat fires on the edge where rcnt would reach REPEAT_DELAY
    localparam logic [CW-1:0] RP_TERM   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    state_t        r_state;
    logic          r_s0;
    logic          r_s1;
    logic [CW-1:0] r_dcnt;
    logic [CW-1:0] r_rcnt;
    logic          w_key_s;

    assign w_key_s = r_s1;

    // Two-flop synchronizer for the asynchronous key input
    always_ff @(posedge ck) begin
        if (!res) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= key_in;
            r_s1 <= r_s0;
        end
    end

    // Qualification FSM with registered level, pulses and repeat step generation
    always_ff @(posedge ck) begin
        if (!res) begin
            r_state       <= ST_IDLE;
            r_dcnt        <= '0;
            r_rcnt        <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_dcnt  <= CNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_key_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_dcnt != DC_TERM) begin
                        r_dcnt <= r_dcnt + CNT_ONE;
                    end else begin
                        r_state     <= ST_HELD;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        step        <= 1'b1;
                        r_rcnt      <= '0;
                    end
                end
                ST_HELD: begin
                    if (!w_key_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_dcnt  <= CNT_ONE;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rcnt == RP_TERM) begin
                            step   <= 1'b1;
                            r_rcnt <= RP_RELOAD;
                        end else begin
                            r_rcnt <= r_rcnt + CNT_ONE;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    // rcnt is left untouched here so repeat timing resumes after a glitch
                    if (w_key_s) begin
                        r_state <= ST_HELD;
                    end else if (r_dcnt != DC_TERM) begin
                        r_dcnt <= r_dcnt + CNT_ONE;
                    end else begin
                        r_state       <= ST_IDLE;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_key_debounce.sv
// Testbench for m_key_debounce: directed scenarios plus randomized key activity,
// checked against a run-length reference model of the debouncer.
module tb_m_key_debounce;

    logic ck = 1'b0;
    logic res_a, key_a, lvl_a, prs_a, rel_a, stp_a;
    logic res_b, key_b, lvl_b, prs_b, rel_b, stp_b;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    bit m_sh0 [2];
    bit m_sh1 [2];
    bit m_lvl [2];
    bit m_prs [2];
    bit m_rel [2];
    bit m_stp [2];
    int m_run [2];
    int m_age [2];

    m_key_debounce #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(0),
        .REPEAT_DELAY(64),
        .REPEAT_PERIOD(16)
    ) dut_a (
        .ck(ck),
        .res(res_a),
        .key_in(key_a),
        .key_level(lvl_a),
        .press_pulse(prs_a),
        .release_pulse(rel_a),
        .step(stp_a)
    );

    m_key_debounce #(
        .DEBOUNCE_CYCLES(2),
        .REPEAT_EN(1),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut_b (
        .ck(ck),
        .res(res_b),
        .key_in(key_b),
        .key_level(lvl_b),
        .press_pulse(prs_b),
        .release_pulse(rel_b),
        .step(stp_b)
    );

    always #5 ck = ~ck;

    // Level flips after n+1 consecutive synchronized samples that disagree with it;
    // repeats occur at hold ages d, d+p, d+2p, ...
    function automatic void model_update(input int i, input bit r, input bit k,
                                         input int n, input bit en, input int d, input int p);
        bit ks;
        m_prs[i] = 1'b0;
        m_rel[i] = 1'b0;
        m_stp[i] = 1'b0;
        if (!r) begin
            m_sh0[i] = 1'b0;
            m_sh1[i] = 1'b0;
            m_lvl[i] = 1'b0;
            m_run[i] = 0;
            m_age[i] = 0;
            return;
        end
        ks       = m_sh1[i];
        m_sh1[i] = m_sh0[i];
        m_sh0[i] = k;
        if (ks != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == n + 1) begin
                m_lvl[i] = ks;
                m_run[i] = 0;
                if (ks) begin
                    m_prs[i] = 1'b1;
                    m_stp[i] = 1'b1;
                    m_age[i] = 0;
                end else begin
                    m_rel[i] = 1'b1;
                end
            end
        end else begin
            if (m_lvl[i] && m_run[i] == 0 && en) begin
                m_age[i]++;
                if (m_age[i] >= d && (m_age[i] - d) % p == 0) m_stp[i] = 1'b1;
            end
            m_run[i] = 0;
        end
    endfunction

    task automatic tick();
        model_update(0, res_a, key_a, 4, 1'b0, 64, 16);
        model_update(1, res_b, key_b, 2, 1'b1, 8, 4);
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        int t_hit;
        int n_hit;
        res_a = 1'b0; key_a = 1'b1;
        res_b = 1'b0; key_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 0000", c, {lvl_a, prs_a, rel_a, stp_a});
            end
        end
        res_a = 1'b1; res_b = 1'b1;
        t_hit = 0; n_hit = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]}) begin
                errors++;
                $display("FAIL reset_model t=%0d: got %b expected %b", t, {lvl_a, prs_a, rel_a, stp_a},
                         {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]});
            end
            if (prs_a === 1'b1 && stp_a === 1'b1) begin
                n_hit++;
                if (t_hit == 0) t_hit = t;
            end
        end
        checks++;
        if (t_hit != 7 || n_hit != 1) begin
            errors++;
            $display("FAIL reset_press_edge: got edge %0d count %0d expected edge 7 count 1", t_hit, n_hit);
        end
        key_a = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        checks++;
        if (lvl_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_level: got %b expected 0", lvl_a);
        end
    endtask

    task automatic test_clean_press();
        key_a = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        key_a = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== {(t >= 7), (t == 7), 1'b0, (t == 7)}) begin
                errors++;
                $display("FAIL clean_press t=%0d: got %b expected %b", t, {lvl_a, prs_a, rel_a, stp_a},
                         {(t >= 7), (t == 7), 1'b0, (t == 7)});
            end
        end
        key_a = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== {(t < 7), 1'b0, (t == 7), 1'b0}) begin
                errors++;
                $display("FAIL clean_release t=%0d: got %b expected %b", t, {lvl_a, prs_a, rel_a, stp_a},
                         {(t < 7), 1'b0, (t == 7), 1'b0});
            end
        end
    endtask

    task automatic test_press_bounce();
        for (int r = 0; r < 11; r++) begin
            for (int j = 0; j < 4; j++) begin
                key_a = (r < 10) ? (j != 3) : 1'b0;
                tick();
                checks++;
                if ({lvl_a, prs_a, rel_a, stp_a} !== 4'b0000 ||
                    {lvl_a, prs_a, rel_a, stp_a} !== {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]}) begin
                    errors++;
                    $display("FAIL press_bounce r=%0d j=%0d: got %b expected 0000", r, j, {lvl_a, prs_a, rel_a, stp_a});
                end
            end
        end
    endtask

    task automatic test_release_glitch();
        key_a = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        checks++;
        if (lvl_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_setup_level: got %b expected 1", lvl_a);
        end
        for (int t = 0; t < 22; t++) begin
            key_a = (t >= 2);
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== 4'b1000 ||
                {lvl_a, prs_a, rel_a, stp_a} !== {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]}) begin
                errors++;
                $display("FAIL release_glitch t=%0d: got %b expected 1000", t, {lvl_a, prs_a, rel_a, stp_a});
            end
        end
        key_a = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        checks++;
        if (lvl_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_final_level: got %b expected 0", lvl_a);
        end
    endtask

    task automatic test_repeat();
        int  t_hit;
        int  q;
        bit  exp_s;
        bit  saw_rel;
        key_b = 1'b1;
        t_hit = 0;
        q = 0;
        for (int t = 1; t <= 12 && t_hit == 0; t++) begin
            tick();
            if (stp_b === 1'b1) begin
                t_hit = t;
                q = (q + 1) % 16;
            end
        end
        checks++;
        if (t_hit != 5) begin
            errors++;
            $display("FAIL repeat_press_edge: got %0d expected 5", t_hit);
        end
        for (int off = 1; off <= 29; off++) begin
            tick();
            exp_s = (off >= 8) && ((off - 8) % 4 == 0);
            if (stp_b === 1'b1) q = (q + 1) % 16;
            checks++;
            if (stp_b !== exp_s || {lvl_b, prs_b, rel_b, stp_b} !== {m_lvl[1], m_prs[1], m_rel[1], m_stp[1]}) begin
                errors++;
                $display("FAIL repeat_step off=%0d: got step %b expected %b", off, stp_b, exp_s);
            end
        end
        key_b = 1'b0;
        saw_rel = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (rel_b === 1'b1) saw_rel = 1'b1;
            if (stp_b === 1'b1) q = (q + 1) % 16;
            checks++;
            if (stp_b !== 1'b0) begin
                errors++;
                $display("FAIL repeat_after_release t=%0d: got step %b expected 0", t, stp_b);
            end
        end
        checks++;
        if (q != 7 || !saw_rel || lvl_b !== 1'b0) begin
            errors++;
            $display("FAIL repeat_count: got q=%0d rel=%0b lvl=%b expected q=7 rel=1 lvl=0", q, saw_rel, lvl_b);
        end
    endtask

    task automatic test_reset_mid_hold();
        key_a = 1'b1;
        for (int t = 0; t < 12; t++) tick();
        checks++;
        if (lvl_a !== 1'b1) begin
            errors++;
            $display("FAIL midhold_setup_level: got %b expected 1", lvl_a);
        end
        res_a = 1'b0;
        tick();
        checks++;
        if ({lvl_a, prs_a, rel_a, stp_a} !== 4'b0000) begin
            errors++;
            $display("FAIL midhold_reset: got %b expected 0000", {lvl_a, prs_a, rel_a, stp_a});
        end
        res_a = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== {(t >= 7), (t == 7), 1'b0, (t == 7)}) begin
                errors++;
                $display("FAIL midhold_requalify t=%0d: got %b expected %b", t, {lvl_a, prs_a, rel_a, stp_a},
                         {(t >= 7), (t == 7), 1'b0, (t == 7)});
            end
        end
        key_a = 1'b0;
        for (int t = 0; t < 12; t++) tick();
    endtask

    task automatic test_random();
        int run_a;
        int run_b;
        run_a = 0;
        run_b = 0;
        for (int t = 0; t < 2000; t++) begin
            if (run_a == 0) begin
                key_a = 1'($urandom_range(0, 1));
                run_a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 7));
            end
            if (run_b == 0) begin
                key_b = 1'($urandom_range(0, 1));
                run_b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 5));
            end
            run_a--;
            run_b--;
            res_a = ($urandom_range(0, 249) != 0);
            res_b = ($urandom_range(0, 249) != 0);
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, stp_a} !== {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]}) begin
                errors++;
                $display("FAIL random_a t=%0d: got %b expected %b", t, {lvl_a, prs_a, rel_a, stp_a},
                         {m_lvl[0], m_prs[0], m_rel[0], m_stp[0]});
            end
            checks++;
            if ({lvl_b, prs_b, rel_b, stp_b} !== {m_lvl[1], m_prs[1], m_rel[1], m_stp[1]}) begin
                errors++;
                $display("FAIL random_b t=%0d: got %b expected %b", t, {lvl_b, prs_b, rel_b, stp_b},
                         {m_lvl[1], m_prs[1], m_rel[1], m_stp[1]});
            end
        end
    endtask

    initial begin
        res_a = 1'b0; key_a = 1'b0;
        res_b = 1'b0; key_b = 1'b0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_glitch();
        test_repeat();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
